// File: rtl/gpio_irq_slave.sv
// rtl/gpio_irq_slave.sv - GPIO bus slave with set/clr/toggle, edge interrupts
// Optional per-pin input debounce filter enabled by defining GPIO_DEBOUNCE_EN.
module gpio_irq_slave #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_WEnable,
    input  logic [31:0]      i_WAddr,
    input  logic [31:0]      i_WData,
    input  logic             i_REnable,
    input  logic [31:0]      i_RAddr,
    output logic [31:0]      o_RData,
    output logic             o_Err,
    output logic             o_Irq,
    inout  wire  [WIDTH-1:0] pin
);

    localparam logic [2:0] REG_DATA = 3'd0;
    localparam logic [2:0] REG_DIR  = 3'd1;
    localparam logic [2:0] REG_SET  = 3'd2;
    localparam logic [2:0] REG_CLR  = 3'd3;
    localparam logic [2:0] REG_TGL  = 3'd4;
    localparam logic [2:0] REG_RISE = 3'd5;
    localparam logic [2:0] REG_FALL = 3'd6;
    localparam logic [2:0] REG_IRQ  = 3'd7;

    logic [WIDTH-1:0] out_q, dir_q, rise_en_q, fall_en_q, irq_stat_q;
    logic [WIDTH-1:0] sync1_q, sync2_q, in_q, in_prev_q;
    logic [WIDTH-1:0] wdata, edge_set, irq_w1c, rd_val;
    logic [31:0]      rd_word;
    logic [2:0]       w_idx, r_idx;
    logic             w_hit, r_hit, w_bad, r_bad;
    logic             unused_ok;

    assign wdata = i_WData[WIDTH-1:0];
    assign w_idx = i_WAddr[2:0];
    assign r_idx = i_RAddr[2:0];
    assign w_hit = i_WEnable && (i_WAddr < 32'd8);
    assign r_hit = i_REnable && (i_RAddr < 32'd8);
    assign w_bad = i_WEnable && !(i_WAddr < 32'd8);
    assign r_bad = i_REnable && !(i_RAddr < 32'd8);
    assign unused_ok = ^{i_WData, 32'(DEBOUNCE_CYCLES)};

    for (genvar g = 0; g < WIDTH; g++) begin : g_pad
        assign pin[g] = dir_q[g] ? out_q[g] : 1'bz;
    end

    // A new qualifying edge is OR-ed in after the clear mask, so set beats W1C.
    assign edge_set = (in_q & ~in_prev_q & rise_en_q) | (~in_q & in_prev_q & fall_en_q);
    assign irq_w1c  = (w_hit && (w_idx == REG_IRQ)) ? wdata : '0;
    assign o_Irq    = |irq_stat_q;

    always_comb begin
        rd_val = '0;
        case (r_idx)
            REG_DATA:                  rd_val = in_q;
            REG_DIR:                   rd_val = dir_q;
            REG_SET, REG_CLR, REG_TGL: rd_val = out_q;
            REG_RISE:                  rd_val = rise_en_q;
            REG_FALL:                  rd_val = fall_en_q;
            REG_IRQ:                   rd_val = irq_stat_q;
        endcase
        rd_word              = '0;
        rd_word[WIDTH-1:0]   = rd_val;
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            out_q      <= '0;
            dir_q      <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            irq_stat_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            in_prev_q  <= '0;
            o_RData    <= '0;
            o_Err      <= 1'b0;
        end else begin
            sync1_q    <= pin;
            sync2_q    <= sync1_q;
            in_prev_q  <= in_q;
            irq_stat_q <= (irq_stat_q & ~irq_w1c) | edge_set;
            if (w_hit) begin
                case (w_idx)
                    REG_DATA: out_q     <= wdata;
                    REG_DIR:  dir_q     <= wdata;
                    REG_SET:  out_q     <= out_q | wdata;
                    REG_CLR:  out_q     <= out_q & ~wdata;
                    REG_TGL:  out_q     <= out_q ^ wdata;
                    REG_RISE: rise_en_q <= wdata;
                    REG_FALL: fall_en_q <= wdata;
                    default:  ;
                endcase
            end
            // Read mux samples pre-write state, so read+write same index returns old value.
            if (r_hit) begin
                o_RData <= rd_word;
            end
            o_Err <= w_bad || r_bad;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] db_cnt_q [WIDTH];

    // Counter tracks consecutive cycles the synchronised pin disagrees with IN.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            in_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2_q[i] == in_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == CNT_LAST) begin
                    in_q[i]     <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                end
            end
        end
    end
`else
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            in_q <= '0;
        end else begin
            in_q <= sync2_q;
        end
    end
`endif

endmodule

// File: tb/tb_gpio_irq_slave.sv
// tb/tb_gpio_irq_slave.sv - directed table-driven bench for gpio_irq_slave
module tb_gpio_irq_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        we, re;
    logic [31:0] wa, wd, ra;
    logic [31:0] rdata;
    logic        err, irq;
    logic [7:0]  ext_en, ext_drv;
    wire  [7:0]  pin;
    int          n_cmp  = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 8; g++) begin : g_ext
        assign pin[g] = ext_en[g] ? ext_drv[g] : 1'bz;
    end

    gpio_irq_slave #(.WIDTH(8), .DEBOUNCE_CYCLES(16)) dut (
        .i_Clk(clk), .i_Rst(rst),
        .i_WEnable(we), .i_WAddr(wa), .i_WData(wd),
        .i_REnable(re), .i_RAddr(ra),
        .o_RData(rdata), .o_Err(err), .o_Irq(irq),
        .pin(pin)
    );

    typedef struct {
        logic        we;
        logic [31:0] wa;
        logic [31:0] wd;
        logic        re;
        logic [31:0] ra;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [27];

    function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic r, input logic [31:0] b,
                                input logic [31:0] e_rd, input logic e_err);
        vec_t v;
        v.we = w; v.wa = a; v.wd = d; v.re = r; v.ra = b;
        v.exp_rd = e_rd; v.exp_err = e_err;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic r, input logic [31:0] b);
        we = w; wa = a; wd = d; re = r; ra = b;
        @(negedge clk);
        we = 1'b0; re = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) tbl[i] = mk(0, 0, 0, 1, i, 32'h0, 0);
        tbl[8]  = mk(1, 1, 32'h0F, 0, 0, 32'h00, 0);
        tbl[9]  = mk(1, 0, 32'h55, 0, 0, 32'h00, 0);
        tbl[10] = mk(0, 0, 0, 1, 1, 32'h0F, 0);
        tbl[11] = mk(0, 0, 0, 1, 2, 32'h55, 0);
        tbl[12] = mk(1, 2, 32'hA0, 0, 0, 32'h55, 0);
        tbl[13] = mk(1, 3, 32'h01, 0, 0, 32'h55, 0);
        tbl[14] = mk(1, 4, 32'h03, 0, 0, 32'h55, 0);
        tbl[15] = mk(0, 0, 0, 1, 4, 32'hF7, 0);
        tbl[16] = mk(1, 5, 32'h80, 1, 5, 32'h00, 0);
        tbl[17] = mk(0, 0, 0, 1, 5, 32'h80, 0);
        tbl[18] = mk(1, 6, 32'h01, 0, 0, 32'h80, 0);
        tbl[19] = mk(0, 0, 0, 1, 6, 32'h01, 0);
        tbl[20] = mk(1, 8, 32'hFF, 0, 0, 32'h01, 1);
        tbl[21] = mk(0, 0, 0, 1, 1, 32'h0F, 0);
        tbl[22] = mk(0, 0, 0, 1, 32'h20, 32'h0F, 1);
        tbl[23] = mk(1, 8, 32'hFF, 1, 32'h20, 32'h0F, 1);
        tbl[24] = mk(1, 32'h100, 32'h00, 1, 3, 32'hF7, 1);
        tbl[25] = mk(0, 0, 0, 1, 0, 32'h07, 0);
        tbl[26] = mk(0, 0, 0, 1, 7, 32'h00, 0);

        rst = 1'b1; we = 1'b0; re = 1'b0; wa = '0; wd = '0; ra = '0;
        ext_en = 8'hFF; ext_drv = 8'h00;
        idle(3);
        check("reset_rdata", rdata, 32'h0);
        check("reset_err", {31'b0, err}, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        rst = 1'b0;

        // All pins are inputs after reset: an external pattern must read back intact.
        ext_drv = 8'hA5;
        idle(4);
        bus(0, 0, 0, 1, 0);
        check("hiz_readback", rdata, 32'hA5);
        ext_drv = 8'h00;
        idle(4);

        for (int i = 0; i < 27; i++) begin
            if (tbl[i].we && tbl[i].wa == 32'd1) ext_en = ~tbl[i].wd[7:0];
            bus(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].re, tbl[i].ra);
            check($sformatf("vec%0d_rdata", i), rdata, tbl[i].exp_rd);
            check($sformatf("vec%0d_err", i), {31'b0, err}, {31'b0, tbl[i].exp_err});
        end
        check("pad_out_nibble", {28'b0, pin[3:0]}, 32'h7);
        check("irq_idle", {31'b0, irq}, 32'h0);

        // Rising edge on input pin 7: o_Irq rises after the third edge.
        ext_drv[7] = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("rise_irq_early", {31'b0, irq}, 32'h0);
        @(posedge clk);
        #1 check("rise_irq_k3", {31'b0, irq}, 32'h1);
        @(negedge clk);
        bus(0, 0, 0, 1, 7);
        check("rise_stat", rdata, 32'h80);
        bus(1, 7, 32'h80, 0, 0);
        check("rise_w1c_irq", {31'b0, irq}, 32'h0);

        // Falling edge on output pin 0 produced by CLR.
        bus(1, 3, 32'h01, 0, 0);
        idle(5);
        bus(0, 0, 0, 1, 7);
        check("fall_stat", rdata, 32'h01);
        check("fall_irq", {31'b0, irq}, 32'h1);
        bus(1, 7, 32'h01, 0, 0);
        bus(0, 0, 0, 1, 7);
        check("fall_w1c", rdata, 32'h00);
        bus(1, 2, 32'h01, 0, 0);
        idle(5);
        bus(0, 0, 0, 1, 7);
        check("rise_not_enabled", rdata, 32'h00);

        // W1C lands on the same edge that latches a new fall: set must win.
        bus(1, 3, 32'h01, 0, 0);
        idle(3);
        bus(1, 7, 32'h01, 0, 0);
        bus(0, 0, 0, 1, 7);
        check("set_wins_stat", rdata, 32'h01);
        check("set_wins_irq", {31'b0, irq}, 32'h1);

        // Asynchronous reset with an interrupt pending.
        rst = 1'b1;
        ext_en = 8'hFF;
        #1;
        check("async_rst_irq", {31'b0, irq}, 32'h0);
        check("async_rst_rdata", rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        bus(0, 0, 0, 1, 1);
        check("post_rst_dir", rdata, 32'h0);
        bus(0, 0, 0, 1, 4);
        check("post_rst_out", rdata, 32'h0);
        bus(0, 0, 0, 1, 7);
        check("post_rst_stat", rdata, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
